wb_cfg_slave: RTL and testbench

Parametrised, synthesizable Wishbone B4 classic-cycle slave. It backs a DEPTH-word register file with byte-lane writes, programmable wait states, ERR on out-of-range addresses, and deterministic RTY injection. It sits behind the bench's Wishbone master as the reference target for coverage-closure runs, and it uses the same slave signal set the benches already drive.

---
 rtl/wb_cfg_pkg.sv | 39 +++
 rtl/wb_cfg_if.sv | 33 +++
 rtl/wb_cfg_bytemem.sv | 27 ++
 rtl/wb_cfg_slave.sv | 200 ++++++++++++++++++++
 tb/tb_wb_cfg_slave.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_cfg_pkg.sv
// Shared types and helpers for the Wishbone configuration slave.
// Holds the FSM and termination encodings, address decode and parameter checks.
package wb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TERM_ACK = 2'd0,
        TERM_ERR = 2'd1,
        TERM_RTY = 2'd2
    } term_e;

    localparam int MAX_AW = 64;

    // Byte address to word index; lsb = log2 of bytes per word.
    function automatic logic [MAX_AW-1:0] word_index(input logic [MAX_AW-1:0] addr,
                                                     input int lsb);
        return addr >> lsb;
    endfunction

    function automatic bit dw_legal(input int dw);
        return (dw == 8) || (dw == 16) || (dw == 32) || (dw == 64);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit cfg_legal(input int dw, input int aw, input int depth,
                                     input int ws, input int re);
        return dw_legal(dw) && depth_legal(depth) && (aw >= 1) && (aw <= MAX_AW) &&
               (ws >= 0) && (ws <= 15) && (re >= 0);
    endfunction

endpackage

// File: rtl/wb_cfg_if.sv
// Wishbone B4 classic slave signal bundle.
// Signal names follow the slave view (_I driven by the master, _O by the slave).
interface wb_cfg_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int TW = 16
);
    logic          CYC_I;
    logic          STB_I;
    logic          WE_I;
    logic [AW-1:0] ADR_I;
    logic [DW/8-1:0] SEL_I;
    logic [DW-1:0] DAT_I;
    logic [TW-1:0] TGA_I;
    logic [TW-1:0] TGC_I;
    logic [TW-1:0] TGD_I;
    logic          LOCK_I;
    logic [DW-1:0] DAT_O;
    logic [TW-1:0] TGD_O;
    logic          ACK_O;
    logic          ERR_O;
    logic          RTY_O;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I, TGA_I, TGC_I, TGD_I, LOCK_I,
        input  DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I, TGA_I, TGC_I, TGD_I, LOCK_I,
        output DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
    );
endinterface

// File: rtl/wb_cfg_bytemem.sv
// DEPTH x DW register storage with per-byte write enables and a combinational read.
// Contents are deliberately not reset.
module wb_cfg_bytemem #(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic [DW/8-1:0]          we_be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < DW / 8; k++) begin
            if (we_be[k]) begin
                mem_q[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_cfg_slave.sv
// Wishbone B4 classic slave backing a byte-writable register file, with
// programmable wait states, out-of-range ERR and periodic RTY injection.
module wb_cfg_slave
    import wb_cfg_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int DEPTH       = 64,
    parameter int TW          = 16,
    parameter int WAIT_STATES = 0,
    parameter int RTY_EVERY   = 0
) (
    input  logic    clk,
    input  logic    rst,
    wb_cfg_if.slave bus
);

    localparam int SW  = DW / 8;
    localparam int LSB = $clog2(SW);
    localparam int AIW = $clog2(DEPTH);
    localparam int RCW = $clog2(RTY_EVERY + 2);

    if (!cfg_legal(DW, AW, DEPTH, WAIT_STATES, RTY_EVERY)) begin : g_bad_cfg
        $error("wb_cfg_slave: illegal parameter combination");
    end

    state_e         state_q, state_d;
    logic [3:0]     wcnt_q, wcnt_d;
    logic [RCW-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic           ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [DW-1:0]  dato_q, dato_d;
    logic [TW-1:0]  tgdo_q, tgdo_d;

    logic [AIW-1:0] idx_q;
    logic           oor_q, we_q, lock_q;
    logic [SW-1:0]  sel_q;
    logic [DW-1:0]  dat_q;
    logic [TW-1:0]  tga_q;

    logic              req;
    logic [MAX_AW-1:0] live_word;
    logic              live_oor;
    logic [AIW-1:0]    live_idx;
    logic              use_capt;
    logic [AIW-1:0]    cur_idx;
    logic              cur_oor, cur_we, cur_lock;
    logic [SW-1:0]     cur_sel;
    logic [DW-1:0]     cur_dat;
    logic [TW-1:0]     cur_tga;
    logic              fire, rty_hit;
    term_e             term;
    logic [SW-1:0]     mem_be;
    logic [DW-1:0]     mem_rdata;
    logic              unused_tags;

    assign unused_tags = ^{bus.TGC_I, bus.TGD_I};

    assign req       = bus.CYC_I & bus.STB_I;
    assign live_word = word_index(MAX_AW'(bus.ADR_I), LSB);
    // DEPTH is a power of two, so any set bit above the index field is out of range.
    assign live_oor  = |live_word[MAX_AW-1:AIW];
    assign live_idx  = live_word[AIW-1:0];

    // While waiting, the request captured in IDLE is the one being served.
    assign use_capt = (state_q == WAIT);
    assign cur_idx  = use_capt ? idx_q  : live_idx;
    assign cur_oor  = use_capt ? oor_q  : live_oor;
    assign cur_we   = use_capt ? we_q   : bus.WE_I;
    assign cur_lock = use_capt ? lock_q : bus.LOCK_I;
    assign cur_sel  = use_capt ? sel_q  : bus.SEL_I;
    assign cur_dat  = use_capt ? dat_q  : bus.DAT_I;
    assign cur_tga  = use_capt ? tga_q  : bus.TGA_I;

    always_comb begin
        rcnt_inc = rcnt_q + RCW'(1);
        rty_hit  = (RTY_EVERY != 0) && !cur_oor && !cur_lock &&
                   (rcnt_inc == RCW'(RTY_EVERY));
        if (cur_oor) begin
            term = TERM_ERR;
        end else if (rty_hit) begin
            term = TERM_RTY;
        end else begin
            term = TERM_ACK;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        fire    = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        dato_d  = '0;
        tgdo_d  = '0;
        mem_be  = '0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        fire = 1'b1;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == 4'd1) begin
                    fire = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Termination is decided and registered on the edge that enters RESP.
        if (fire) begin
            state_d = RESP;
            wcnt_d  = '0;
            if (!cur_oor && !cur_lock && (RTY_EVERY != 0)) begin
                rcnt_d = rty_hit ? '0 : rcnt_inc;
            end
            unique case (term)
                TERM_ERR: err_d = 1'b1;
                TERM_RTY: rty_d = 1'b1;
                default: begin
                    ack_d = 1'b1;
                    if (cur_we) begin
                        // Gate with reset so a write racing reset assertion is dropped.
                        if (rst) mem_be = cur_sel;
                    end else begin
                        dato_d = mem_rdata;
                        tgdo_d = cur_tga;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            dato_q  <= '0;
            tgdo_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            dato_q  <= dato_d;
            tgdo_q  <= tgdo_d;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && req) begin
            idx_q  <= live_idx;
            oor_q  <= live_oor;
            we_q   <= bus.WE_I;
            lock_q <= bus.LOCK_I;
            sel_q  <= bus.SEL_I;
            dat_q  <= bus.DAT_I;
            tga_q  <= bus.TGA_I;
        end
    end

    wb_cfg_bytemem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we_be (mem_be),
        .waddr (cur_idx),
        .wdata (cur_dat),
        .raddr (cur_idx),
        .rdata (mem_rdata)
    );

    assign bus.ACK_O = ack_q;
    assign bus.ERR_O = err_q;
    assign bus.RTY_O = rty_q;
    assign bus.DAT_O = dato_q;
    assign bus.TGD_O = tgdo_q;

endmodule

// File: tb/tb_wb_cfg_slave.sv
// Directed scoreboard bench for wb_cfg_slave: four instances cover zero wait,
// three wait states, retry injection and five wait states with abort/reset.
module tb_wb_cfg_slave;

    localparam logic [2:0] T_ACK = 3'b001;
    localparam logic [2:0] T_RTY = 3'b010;
    localparam logic [2:0] T_ERR = 3'b100;

    typedef struct {
        logic [2:0]  term;
        int          lat;
        bit          chk_dat;
        logic [31:0] dat;
        bit          chk_tgd;
        logic [15:0] tgd;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst5;
    logic [3:0] rstv;

    logic [3:0]  cyc, stb, we, lock;
    logic [31:0] adr   [4];
    logic [31:0] dat_i [4];
    logic [3:0]  sel   [4];
    logic [15:0] tga   [4];
    logic [15:0] tgc   [4];
    logic [15:0] tgd   [4];
    logic [31:0] dato  [4];
    logic [15:0] tgdo  [4];
    logic [3:0]  ack, err, rty;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign rstv = {rst5, rst0, rst0, rst0};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WS = (g == 1) ? 3 : ((g == 3) ? 5 : 0);
        localparam int RE = (g == 2) ? 3 : 0;

        wb_cfg_if #(.DW(32), .AW(32), .TW(16)) bus ();

        assign bus.CYC_I  = cyc[g];
        assign bus.STB_I  = stb[g];
        assign bus.WE_I   = we[g];
        assign bus.ADR_I  = adr[g];
        assign bus.SEL_I  = sel[g];
        assign bus.DAT_I  = dat_i[g];
        assign bus.TGA_I  = tga[g];
        assign bus.TGC_I  = tgc[g];
        assign bus.TGD_I  = tgd[g];
        assign bus.LOCK_I = lock[g];
        assign dato[g]    = bus.DAT_O;
        assign tgdo[g]    = bus.TGD_O;
        assign ack[g]     = bus.ACK_O;
        assign err[g]     = bus.ERR_O;
        assign rty[g]     = bus.RTY_O;

        wb_cfg_slave #(
            .DW          (32),
            .AW          (32),
            .DEPTH       (64),
            .TW          (16),
            .WAIT_STATES (WS),
            .RTY_EVERY   (RE)
        ) u_dut (
            .clk (clk),
            .rst (rstv[g]),
            .bus (bus)
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs_zero(input int d, input string tag);
        chk(tag, {ack[d], err[d], rty[d], dato[d], tgdo[d]}, 64'd0);
    endtask

    task automatic drive(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input bit lk, input logic [15:0] tg);
        cyc[d]   = 1'b1;
        stb[d]   = 1'b1;
        we[d]    = w;
        adr[d]   = a;
        dat_i[d] = wd;
        sel[d]   = s;
        lock[d]  = lk;
        tga[d]   = tg;
        tgc[d]   = ~tg;
        tgd[d]   = tg ^ 16'h5a5a;
    endtask

    task automatic quiet(input int d, input int n, input string tag);
        int hits = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (ack[d] | err[d] | rty[d]) hits++;
        end
        chk(tag, hits, 0);
    endtask

    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input bit lk, input logic [15:0] tg,
                        input int lat, input logic [2:0] term, input logic [31:0] edat,
                        input bit rst_resp, input string tag);
        exp_t e;
        int   k;
        bit   seen;
        @(negedge clk);
        drive(d, w, a, wd, s, lk, tg);
        e.term    = term;
        e.lat     = lat;
        e.chk_dat = !w || (term == T_ERR);
        e.dat     = edat;
        e.chk_tgd = !w && (term == T_ACK);
        e.tgd     = tg;
        sb.push_back(e);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            seen = ack[d] | err[d] | rty[d];
        end
        e = sb.pop_front();
        chk({tag, " done"}, seen, 1);
        if (seen) begin
            chk({tag, " term"}, {err[d], rty[d], ack[d]}, e.term);
            chk({tag, " lat"}, k, e.lat);
            if (e.chk_dat) chk({tag, " dat"}, dato[d], e.dat);
            if (e.chk_tgd) chk({tag, " tgd"}, tgdo[d], e.tgd);
        end
        cyc[d]  = 1'b0;
        stb[d]  = 1'b0;
        we[d]   = 1'b0;
        lock[d] = 1'b0;
        if (rst_resp) begin
            #1 rst5 = 1'b0;
            #1 outs_zero(d, {tag, " rst_async"});
        end
        @(posedge clk);
        #1;
        chk({tag, " single"}, {err[d], rty[d], ack[d]}, 3'b000);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed still running, required finished");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b0;
        rst5 = 1'b0;
        cyc  = '0;
        stb  = '0;
        we   = '0;
        lock = '0;
        for (int i = 0; i < 4; i++) begin
            adr[i]   = '0;
            dat_i[i] = '0;
            sel[i]   = '0;
            tga[i]   = '0;
            tgc[i]   = '0;
            tgd[i]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) outs_zero(i, $sformatf("reset%0d", i));
        @(negedge clk);
        rst0 = 1'b1;
        rst5 = 1'b1;

        // Zero wait states: full write, byte-lane merge, decode errors, unaligned read.
        xfer(0, 1, 32'h10,  32'hDEADBEEF, 4'hF,    0, 16'h0001, 1, T_ACK, 32'h0, 0, "wr_full");
        xfer(0, 0, 32'h10,  32'h0,        4'hF,    0, 16'h1234, 1, T_ACK, 32'hDEADBEEF, 0, "rd_full");
        xfer(0, 1, 32'h10,  32'h11223344, 4'b0101, 0, 16'h0002, 1, T_ACK, 32'h0, 0, "wr_sel5");
        xfer(0, 0, 32'h10,  32'h0,        4'h0,    0, 16'h00A5, 1, T_ACK, 32'hDE22BE44, 0, "rd_sel5");
        xfer(0, 0, 32'h100, 32'h0,        4'hF,    0, 16'h0BAD, 1, T_ERR, 32'h0, 0, "rd_oor");
        xfer(0, 1, 32'h110, 32'hFFFFFFFF, 4'hF,    0, 16'h0003, 1, T_ERR, 32'h0, 0, "wr_oor");
        xfer(0, 0, 32'h13,  32'h0,        4'hF,    0, 16'h7777, 1, T_ACK, 32'hDE22BE44, 0, "rd_unaligned");

        // Three wait states.
        xfer(1, 1, 32'h20,  32'hCAFEF00D, 4'hF, 0, 16'h0010, 4, T_ACK, 32'h0, 0, "ws3_wr");
        xfer(1, 0, 32'h20,  32'h0,        4'hF, 0, 16'h4321, 4, T_ACK, 32'hCAFEF00D, 0, "ws3_rd");
        xfer(1, 0, 32'h400, 32'h0,        4'hF, 0, 16'h0011, 4, T_ERR, 32'h0, 0, "ws3_oor");

        // Retry every third unlocked transfer; locked traffic seeds and reads back.
        for (int i = 0; i < 6; i++)
            xfer(2, 1, 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 1, 16'h0100, 1, T_ACK, 32'h0, 0,
                 $sformatf("lock_wr%0d", i));
        for (int i = 0; i < 6; i++)
            xfer(2, 1, 32'(i * 4), 32'hB0 + 32'(i), 4'hF, 0, 16'h0200, 1,
                 ((i % 3) == 2) ? T_RTY : T_ACK, 32'h0, 0, $sformatf("rty_wr%0d", i));
        for (int i = 0; i < 6; i++)
            xfer(2, 0, 32'(i * 4), 32'h0, 4'hF, 1, 16'h0300 + 16'(i), 1, T_ACK,
                 ((i % 3) == 2) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i), 0,
                 $sformatf("rty_rd%0d", i));

        // Five wait states: abort mid-wait, reset mid-wait, reset during a response.
        xfer(3, 1, 32'h30, 32'h55AA55AA, 4'hF, 0, 16'h0400, 6, T_ACK, 32'h0, 0, "ws5_init");
        @(negedge clk);
        drive(3, 1, 32'h30, 32'h0BADF00D, 4'hF, 0, 16'h0401);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc[3] = 1'b0;
        stb[3] = 1'b0;
        quiet(3, 10, "abort_quiet");
        xfer(3, 0, 32'h30, 32'h0, 4'hF, 0, 16'h0402, 6, T_ACK, 32'h55AA55AA, 0, "rd_after_abort");

        @(negedge clk);
        drive(3, 1, 32'h30, 32'h12345678, 4'hF, 0, 16'h0403);
        @(posedge clk);
        @(posedge clk);
        #2 rst5 = 1'b0;
        #1 outs_zero(3, "rst_wait");
        cyc[3] = 1'b0;
        stb[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst5 = 1'b1;
        quiet(3, 8, "rst_quiet");
        xfer(3, 0, 32'h30, 32'h0, 4'hF, 0, 16'h0404, 6, T_ACK, 32'h55AA55AA, 0, "rd_after_rst");

        xfer(3, 0, 32'h30, 32'h0, 4'hF, 0, 16'h0405, 6, T_ACK, 32'h55AA55AA, 1, "rd_rst_resp");
        @(negedge clk);
        rst5 = 1'b1;
        xfer(3, 0, 32'h30, 32'h0, 4'hF, 0, 16'h0406, 6, T_ACK, 32'h55AA55AA, 0, "rd_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
